pixie_dp_front_end: RTL and testbench

- CPU-side half of the 1861-style display pipeline: counts pixie line and byte-slot timing, and generates the 1802 interrupt, EF flag and DMA-out requests.
- Captures the DMA-out bytes supplied by the CPU and writes them into the dual-port frame buffer (write port) at {row, byte}. The display back end reads the same buffer through the other port.
- Frame buffer geometry is 128 rows x 8 bytes = 1024 bytes.

---
 rtl/pixie_pkg.sv | 33 +++
 rtl/pixie_dp_front_end_if.sv | 30 +++
 rtl/pixie_line_timer.sv | 41 ++++
 rtl/pixie_dp_front_end.sv | 120 ++++++++++++
 tb/tb_pixie_dp_front_end.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/pixie_pkg.sv
// Shared pixie display geometry, frame buffer address width and DMA state type.
// Used by both the CPU-side front end and the display back end.
package pixie_pkg;

    localparam int BYTES_PER_LINE    = 14;
    localparam int LINES_PER_FRAME   = 262;
    localparam int FIRST_ACTIVE_LINE = 64;
    localparam int ACTIVE_LINES      = 128;
    localparam int BYTES_PER_ROW     = 8;

    localparam int DMA_START_SLOT    = 2;
    localparam int INT_LINES         = 2;
    localparam int EF_LINES          = 4;

    localparam int FB_AW  = 10;
    localparam int SLOT_W = 4;
    localparam int LINE_W = 9;

    typedef logic [SLOT_W-1:0] slot_t;
    typedef logic [LINE_W-1:0] line_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SLOT,
        REQ,
        DONE
    } dma_state_t;

    function automatic logic in_range(line_t l, int lo, int hi);
        return (int'(l) >= lo) && (int'(l) <= hi);
    endfunction

endpackage

// File: rtl/pixie_dp_front_end_if.sv
// CPU DMA-out handshake plus the frame buffer write port of the pixie front end.
// master = front end (drives request and buffer writes), slave = CPU/buffer side.
interface pixie_dp_front_end_if;

    logic                       dma_req;
    logic                       dma_ack;
    logic [7:0]                 dma_data;
    logic                       fb_we;
    logic [pixie_pkg::FB_AW-1:0] fb_addr;
    logic [7:0]                 fb_wdata;

    modport master (
        output dma_req,
        output fb_we,
        output fb_addr,
        output fb_wdata,
        input  dma_ack,
        input  dma_data
    );

    modport slave (
        input  dma_req,
        input  fb_we,
        input  fb_addr,
        input  fb_wdata,
        output dma_ack,
        output dma_data
    );

endinterface

// File: rtl/pixie_line_timer.sv
// Byte-slot and scan-line counters with registered line_start/frame_start pulses.
// adv/line_nxt are combinational so callers can act in the same clk the line advances.
module pixie_line_timer
    import pixie_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  slot_tick,
    output slot_t slot,
    output line_t line,
    output logic  adv,
    output line_t line_nxt,
    output logic  line_start,
    output logic  frame_start
);

    logic last_line;

    assign adv       = slot_tick && (slot == slot_t'(BYTES_PER_LINE - 1));
    assign last_line = (line == line_t'(LINES_PER_FRAME - 1));
    assign line_nxt  = last_line ? '0 : line + line_t'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            slot        <= '0;
            line        <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= adv;
            frame_start <= adv && last_line;
            if (adv) begin
                slot <= '0;
                line <= line_nxt;
            end else if (slot_tick) begin
                slot <= slot + slot_t'(1);
            end
        end
    end

endmodule

// File: rtl/pixie_dp_front_end.sv
// CPU side of the pixie pipeline: line timing, INT/EF, DMA-out requests and frame buffer writes.
// One clk from dma_ack to fb_we; the CPU paces transfers by acking only while dma_req is high.
module pixie_dp_front_end
    import pixie_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        slot_tick,
    input  logic                        disp_on,
    input  logic                        disp_off,
    pixie_dp_front_end_if.master        cpu_fb,
    output logic                        int_n,
    output logic                        efx,
    output logic                        line_start,
    output logic                        frame_start,
    output logic                        underrun
);

    localparam int LAST_ACTIVE = FIRST_ACTIVE_LINE + ACTIVE_LINES - 1;

    slot_t      slot;
    line_t      line;
    line_t      line_nxt;
    logic       adv;

    dma_state_t state;
    logic [3:0] byte_idx;
    logic       disp_en;
    logic       dma_req_q;
    logic       fb_we_q;
    logic [FB_AW-1:0] fb_addr_q;
    logic [7:0] fb_wdata_q;

    logic       accept;
    logic       last_byte;
    logic       active_nxt;
    logic [6:0] row;

    pixie_line_timer u_timer (
        .clk         (clk),
        .reset       (reset),
        .slot_tick   (slot_tick),
        .slot        (slot),
        .line        (line),
        .adv         (adv),
        .line_nxt    (line_nxt),
        .line_start  (line_start),
        .frame_start (frame_start)
    );

    assign accept     = dma_req_q && cpu_fb.dma_ack;
    assign last_byte  = (byte_idx == 4'(BYTES_PER_ROW - 1));
    assign active_nxt = in_range(line_nxt, FIRST_ACTIVE_LINE, LAST_ACTIVE);
    assign row        = 7'(line - line_t'(FIRST_ACTIVE_LINE));

    assign cpu_fb.dma_req  = dma_req_q;
    assign cpu_fb.fb_we    = fb_we_q;
    assign cpu_fb.fb_addr  = fb_addr_q;
    assign cpu_fb.fb_wdata = fb_wdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            byte_idx   <= '0;
            disp_en    <= 1'b0;
            dma_req_q  <= 1'b0;
            fb_we_q    <= 1'b0;
            fb_addr_q  <= '0;
            fb_wdata_q <= '0;
            int_n      <= 1'b1;
            efx        <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            disp_en <= disp_off ? 1'b0 : (disp_on ? 1'b1 : disp_en);

            fb_we_q <= accept;
            if (accept) begin
                fb_addr_q  <= {row, byte_idx[2:0]};
                fb_wdata_q <= cpu_fb.dma_data;
            end

            // Interrupt holds from the INT lines until the first byte of the first active line.
            int_n <= !(disp_en &&
                       (in_range(line, FIRST_ACTIVE_LINE - INT_LINES, FIRST_ACTIVE_LINE - 1) ||
                        (line == line_t'(FIRST_ACTIVE_LINE) && byte_idx == 4'd0 && !accept)));

            efx <= in_range(line, FIRST_ACTIVE_LINE - EF_LINES, FIRST_ACTIVE_LINE - 1) ||
                   in_range(line, LAST_ACTIVE - EF_LINES + 1, LAST_ACTIVE);

            if (adv) begin
                // disp_en is latched here as the line enable: the chosen state carries it.
                if (state == WAIT_SLOT || (state == REQ && !(accept && last_byte)))
                    underrun <= 1'b1;
                state     <= (disp_en && active_nxt) ? WAIT_SLOT : IDLE;
                byte_idx  <= '0;
                dma_req_q <= 1'b0;
            end else begin
                case (state)
                    WAIT_SLOT: begin
                        if (slot_tick && slot == slot_t'(DMA_START_SLOT - 1)) begin
                            state     <= REQ;
                            dma_req_q <= 1'b1;
                        end
                    end
                    REQ: begin
                        if (accept) begin
                            byte_idx <= byte_idx + 4'd1;
                            if (last_byte) begin
                                state     <= DONE;
                                dma_req_q <= 1'b0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pixie_dp_front_end.sv
// Randomized bench for pixie_dp_front_end against a line/slot/byte-count reference model.
// Directed phases walk through the display on/off, underrun and mid-line reset scenarios.
module tb_pixie_dp_front_end;

    logic clk = 1'b0;
    logic reset, slot_tick, disp_on, disp_off;
    logic int_n, efx, line_start, frame_start, underrun;

    pixie_dp_front_end_if bus();

    pixie_dp_front_end dut (
        .clk         (clk),
        .reset       (reset),
        .slot_tick   (slot_tick),
        .disp_on     (disp_on),
        .disp_off    (disp_off),
        .cpu_fb      (bus),
        .int_n       (int_n),
        .efx         (efx),
        .line_start  (line_start),
        .frame_start (frame_start),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: position in the frame and bytes taken on the current line.
    int m_slot, m_line, m_taken;
    bit m_disp_en, m_line_en;
    bit e_req, e_we, e_int_n, e_efx, e_ls, e_fs, e_und;
    int e_addr, e_wdata;

    int obs_row[128];
    int obs_we_total, obs_req, obs_intlow;
    logic [31:0] first101;
    bit first101_set;
    int tick_total = 0;
    bit limit100;

    function automatic bit active(int l);
        return l >= 64 && l <= 191;
    endfunction

    task automatic model_step(bit rst, bit tick, bit on, bit off, bit ack, int data);
        bit acc, adv;
        if (rst) begin
            m_slot = 0; m_line = 0; m_taken = 0; m_disp_en = 0; m_line_en = 0;
            e_req = 0; e_we = 0; e_addr = 0; e_wdata = 0; e_int_n = 1; e_efx = 0;
            e_ls = 0; e_fs = 0; e_und = 0;
            return;
        end
        acc = e_req && ack;
        adv = tick && m_slot == 13;
        e_we = acc;
        if (acc) begin
            e_addr  = ((m_line - 64) & 127) * 8 + (m_taken % 8);
            e_wdata = data;
            m_taken++;
        end
        e_int_n = !(m_disp_en && m_line >= 62 && m_line <= 64 && !(m_line == 64 && m_taken > 0));
        e_efx   = (m_line >= 60 && m_line <= 63) || (m_line >= 188 && m_line <= 191);
        e_ls    = adv;
        e_fs    = adv && m_line == 261;
        if (adv) begin
            if (m_line_en && active(m_line) && m_taken < 8) e_und = 1;
            m_line_en = m_disp_en;
            m_line    = (m_line + 1) % 262;
            m_slot    = 0;
            m_taken   = 0;
            e_req     = 0;
        end else begin
            if (tick) m_slot++;
            e_req = m_line_en && active(m_line) && m_slot >= 2 && m_taken < 8;
        end
        m_disp_en = off ? 1'b0 : (on ? 1'b1 : m_disp_en);
    endtask

    task automatic clear_obs();
        for (int i = 0; i < 128; i++) obs_row[i] = 0;
        obs_we_total = 0; obs_req = 0; obs_intlow = 0;
        first101 = '0; first101_set = 0;
    endtask

    task automatic cycle(bit rst, bit tick, bit on, bit off, bit ack, logic [7:0] data);
        reset = rst; slot_tick = tick; disp_on = on; disp_off = off;
        bus.dma_ack = ack; bus.dma_data = data;
        if (tick && !rst) tick_total++;
        model_step(rst, tick, on, off, ack, int'(data));
        @(posedge clk);
        #1;
        chk("dma_req", bus.dma_req, e_req);
        chk("fb_we", bus.fb_we, e_we);
        if (e_we) begin
            chk("fb_addr", bus.fb_addr, e_addr);
            chk("fb_wdata", bus.fb_wdata, e_wdata);
        end
        chk("int_n", int_n, e_int_n);
        chk("efx", efx, e_efx);
        chk("line_start", line_start, e_ls);
        chk("frame_start", frame_start, e_fs);
        chk("underrun", underrun, e_und);
        if (bus.fb_we === 1'b1) begin
            obs_we_total++;
            obs_row[bus.fb_addr[9:3]]++;
            if (bus.fb_addr[9:3] == 7'd37 && !first101_set) begin
                first101 = 32'(bus.fb_addr);
                first101_set = 1;
            end
        end
        if (bus.dma_req === 1'b1) obs_req++;
        if (int_n === 1'b0) obs_intlow++;
    endtask

    task automatic one_cycle(int ack_pct, int spur_pct, bit on = 0, bit off = 0, bit rst = 0);
        bit tick, ack;
        logic [7:0] data;
        tick = ($urandom_range(0, 2) != 0);
        if (e_req) ack = (int'($urandom_range(0, 99)) < ack_pct);
        else       ack = (int'($urandom_range(0, 99)) < spur_pct);
        if (limit100 && m_line == 100 && m_taken >= 5) ack = 0;
        data = (m_line == 64) ? 8'(8'h11 * (m_taken + 1)) : 8'($urandom_range(0, 255));
        cycle(rst, tick, on, off, ack, data);
    endtask

    task automatic run_line_to(int target, int ack_pct, int spur_pct);
        int guard = 0;
        while (m_line != target && guard < 20000) begin
            one_cycle(ack_pct, spur_pct);
            guard++;
        end
        if (m_line != target) chk("reach_line", 32'(m_line), 32'(target));
    endtask

    initial begin
        int g;
        int t0;
        limit100 = 1;
        clear_obs();
        repeat (3) cycle(1, 0, 0, 0, 0, 8'h00);
        chk("rst_int_n", int_n, 1'b1);
        chk("rst_underrun", underrun, 1'b0);

        // Frame 0: display on, full lines except a short line 100.
        one_cycle(100, 0, 1, 0);
        run_line_to(62, 100, 0);
        repeat (2) one_cycle(100, 0);
        chk("int_n_l62", int_n, 1'b0);
        chk("efx_l62", efx, 1'b1);
        clear_obs();
        run_line_to(99, 100, 0);
        chk("underrun_l99", underrun, 1'b0);
        run_line_to(102, 100, 0);
        chk("wr_l64", obs_row[0], 8);
        chk("wr_l100", obs_row[36], 5);
        chk("first_l101", first101, 32'h128);
        chk("underrun_l101", underrun, 1'b1);
        limit100 = 0;

        // Frame 1: display off mid-line 70; line 70 still completes.
        run_line_to(0, 100, 0);
        run_line_to(70, 100, 0);
        clear_obs();
        g = 0;
        while (m_slot != 5 && g < 200) begin
            one_cycle(100, 0);
            g++;
        end
        one_cycle(100, 0, 0, 1);
        run_line_to(71, 100, 0);
        chk("wr_l70", obs_row[6], 8);
        clear_obs();
        run_line_to(189, 100, 25);
        repeat (2) one_cycle(100, 25);
        chk("efx_l189", efx, 1'b1);
        run_line_to(250, 100, 25);
        one_cycle(100, 25, 1, 1);

        // Frame 2: display must stay off; spurious acks must not write.
        run_line_to(0, 100, 25);
        run_line_to(250, 100, 25);
        chk("we_quiet", obs_we_total, 0);
        chk("req_quiet", obs_req, 0);
        chk("int_quiet", obs_intlow, 0);

        // Frame 3: random traffic, then reset in the middle of a line's transfer.
        one_cycle(50, 5, 1, 0);
        run_line_to(0, 50, 5);
        run_line_to(150, 50, 5);
        g = 0;
        while (!(e_req && m_taken == 3) && g < 20000) begin
            one_cycle(50, 5);
            g++;
        end
        if (!(e_req && m_taken == 3)) chk("reach_byte3", 32'(m_taken), 32'd3);
        one_cycle(100, 5, 0, 0, 1);
        t0 = tick_total;
        chk("rst_mid_req", bus.dma_req, 1'b0);
        chk("rst_mid_we", bus.fb_we, 1'b0);
        chk("rst_mid_int_n", int_n, 1'b1);
        chk("rst_mid_underrun", underrun, 1'b0);
        g = 0;
        while (frame_start !== 1'b1 && g < 20000) begin
            one_cycle(50, 5);
            g++;
        end
        chk("ticks_to_wrap", 32'(tick_total - t0), 32'd3668);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
